// File: rtl/dmem_arbiter_pkg.sv
// Shared types and the round-robin search helper for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int MAX_REQ   = 16;
  localparam int MAX_IDX_W = $clog2(MAX_REQ);

  typedef enum logic {ARB, LOCKED} arb_state_t;

  // One-hot pick of the first unmasked requester after ptr, searching cyclically over n ports.
  function automatic logic [MAX_REQ-1:0] rr_next(
    input logic [MAX_REQ-1:0] req,
    input int                 ptr,
    input logic [MAX_REQ-1:0] mask,
    input int                 n
  );
    logic [MAX_REQ-1:0]   pick;
    logic [MAX_IDX_W-1:0] idx;
    pick = '0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        idx = MAX_IDX_W'((ptr + k) % n);
        if (req[idx] && !mask[idx]) begin
          pick      = '0;
          pick[idx] = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester bus plus data_memory port seen by the arbiter.
interface dmem_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ-1:0]        we;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;
  logic                    stall;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_we;
  logic [DATA_W-1:0]       mem_wd;
  logic [DATA_W-1:0]       mem_rd;

  modport master (
    output req, lock, we, addr, wdata, mem_rd,
    input  gnt, rvalid, rdata, stall, mem_addr, mem_we, mem_wd
  );

  modport slave (
    input  req, lock, we, addr, wdata, mem_rd,
    output gnt, rvalid, rdata, stall, mem_addr, mem_we, mem_wd
  );
endinterface

// File: rtl/dmem_arbiter_picker.sv
// Combinational round-robin picker: first requester after ptr not in exclude_mask.
module rr_priority_picker
  import dmem_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_REQ-1:0] exclude_mask,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx
);

  logic [MAX_REQ-1:0] pick;

  // Bits above N_REQ are always zero, so scanning the full width keeps idx exact.
  always_comb begin
    pick   = rr_next(MAX_REQ'(req), int'(ptr), MAX_REQ'(exclude_mask), N_REQ);
    onehot = pick[N_REQ-1:0];
    idx    = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (pick[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded locked bursts sharing one single-port data memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  arb_state_t        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  owner;
  logic [CNT_W-1:0]  lock_cnt;
  logic [N_REQ-1:0]  rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  logic [N_REQ-1:0]  owner_oh;
  logic [N_REQ-1:0]  excl;
  logic [N_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic [N_REQ-1:0]  gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              owner_req;
  logic              owner_lock;
  logic              others_wait;
  logic              preempt;
  logic              any_gnt;
  logic              gnt_we;
  logic              gnt_lock;

  // While locked the same picker serves the preemption case, so the owner is masked out.
  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
    excl            = (state == LOCKED) ? owner_oh : '0;
    owner_req       = |(bus.req & owner_oh);
    owner_lock      = |(bus.lock & owner_oh);
    others_wait     = |(bus.req & ~owner_oh);
    preempt         = (state == LOCKED) && owner_req && (lock_cnt == CNT_MAX) && others_wait;
  end

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req          (bus.req),
    .ptr          (rr_ptr),
    .exclude_mask (excl),
    .onehot       (pick_oh),
    .idx          (pick_idx)
  );

  always_comb begin
    gnt     = '0;
    gnt_idx = owner;
    if (!rst) begin
      if (state == ARB || preempt) begin
        gnt     = pick_oh;
        gnt_idx = pick_idx;
      end else if (owner_req) begin
        gnt = owner_oh;
      end
    end
    any_gnt  = |gnt;
    gnt_we   = |(bus.we & gnt);
    gnt_lock = |(bus.lock & gnt);
  end

  always_comb begin
    bus.mem_addr = '0;
    bus.mem_we   = 1'b0;
    bus.mem_wd   = '0;
    if (any_gnt) begin
      bus.mem_addr = bus.addr[gnt_idx*ADDR_W +: ADDR_W];
      bus.mem_we   = gnt_we;
      bus.mem_wd   = bus.wdata[gnt_idx*DATA_W +: DATA_W];
    end
  end

  assign bus.gnt    = gnt;
  assign bus.stall  = bus.req[0] & ~gnt[0];
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB;
      rr_ptr   <= IDX_W'(N_REQ - 1);
      owner    <= '0;
      lock_cnt <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= '0;
      if (any_gnt) begin
        rr_ptr <= gnt_idx;
        if (!gnt_we) begin
          rvalid_q <= gnt;
          rdata_q  <= bus.mem_rd;
        end
      end
      case (state)
        ARB: begin
          if (any_gnt && gnt_lock) begin
            state    <= LOCKED;
            owner    <= gnt_idx;
            lock_cnt <= CNT_W'(1);
          end
        end
        LOCKED: begin
          if (!owner_req || !owner_lock || preempt) begin
            state    <= ARB;
            lock_cnt <= '0;
          end else if (lock_cnt != CNT_MAX) begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter against a queue-free integer reference model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int N_REQ      = 2;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int LOCK_MAX   = 8;
  localparam int WAIT_BOUND = (N_REQ - 1) * LOCK_MAX + N_REQ;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(
    .N_REQ    (N_REQ),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DATA_W-1:0] dut_mem [16];
  logic [DATA_W-1:0] ref_mem [16];

  assign bus.mem_rd = dut_mem[bus.mem_addr[3:0]];
  always @(posedge clk) if (bus.mem_we) dut_mem[bus.mem_addr[3:0]] <= bus.mem_wd;

  int checks   = 0;
  int failures = 0;

  bit                m_locked;
  int                m_owner;
  int                m_count;
  int                m_last;
  logic [N_REQ-1:0]  exp_rvalid;
  logic [DATA_W-1:0] exp_rdata;
  logic [N_REQ-1:0]  last_gnt;
  int                wait_cnt [N_REQ];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic setPort(input int i, input logic r, input logic l, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req[i]                     = r;
    bus.lock[i]                    = l;
    bus.we[i]                      = w;
    bus.addr[i*ADDR_W +: ADDR_W]   = a;
    bus.wdata[i*DATA_W +: DATA_W]  = d;
  endtask

  task automatic modelReset();
    m_locked   = 1'b0;
    m_owner    = 0;
    m_count    = 0;
    m_last     = N_REQ - 1;
    exp_rvalid = '0;
    exp_rdata  = '0;
  endtask

  function automatic int rrSearch(input int start, input int skip);
    for (int k = 1; k <= N_REQ; k++) begin
      int i;
      i = (start + k) % N_REQ;
      if (bus.req[i] && i != skip) return i;
    end
    return -1;
  endfunction

  // Expected winner this cycle, -1 for nobody.
  function automatic int modelWinner();
    int w;
    if (rst) return -1;
    if (!m_locked) return rrSearch(m_last, -1);
    if (!bus.req[m_owner]) return -1;
    if (m_count >= LOCK_MAX) begin
      w = rrSearch(m_last, m_owner);
      if (w >= 0) return w;
    end
    return m_owner;
  endfunction

  task automatic modelUpdate(input int w);
    logic [3:0] a;
    exp_rvalid = '0;
    if (w >= 0) begin
      m_last = w;
      a = bus.addr[w*ADDR_W +: 4];
      if (bus.we[w]) ref_mem[a] = bus.wdata[w*DATA_W +: DATA_W];
      else begin
        exp_rvalid[w] = 1'b1;
        exp_rdata     = ref_mem[a];
      end
    end
    if (!m_locked) begin
      if (w >= 0 && bus.lock[w]) begin
        m_locked = 1'b1;
        m_owner  = w;
        m_count  = 1;
      end
    end else if (w == m_owner && bus.lock[w]) begin
      if (m_count < LOCK_MAX) m_count++;
    end else begin
      m_locked = 1'b0;
    end
  endtask

  // One clock cycle: check combinational outputs, step the model, check registered outputs.
  task automatic runCycle(output int won);
    int w;
    logic [N_REQ-1:0]  eg;
    logic [ADDR_W-1:0] ea;
    logic              ewe;
    logic [DATA_W-1:0] ewd;
    #1;
    w   = modelWinner();
    won = w;
    eg  = '0;
    ea  = '0;
    ewe = 1'b0;
    ewd = '0;
    if (w >= 0) begin
      eg[w] = 1'b1;
      ea    = bus.addr[w*ADDR_W +: ADDR_W];
      ewe   = bus.we[w];
      ewd   = bus.wdata[w*DATA_W +: DATA_W];
    end
    last_gnt = bus.gnt;
    checkOutput("gnt", bus.gnt, eg);
    checkOutput("stall", bus.stall, bus.req[0] & ~eg[0]);
    checkOutput("mem_addr", bus.mem_addr, ea);
    checkOutput("mem_we", bus.mem_we, ewe);
    checkOutput("mem_wd", bus.mem_wd, ewd);
    @(posedge clk);
    if (!rst) modelUpdate(w);
    #1;
    checkOutput("rvalid", bus.rvalid, exp_rvalid);
    checkOutput("rdata", bus.rdata, exp_rdata);
    @(negedge clk);
  endtask

  task automatic clearPorts();
    for (int i = 0; i < N_REQ; i++) setPort(i, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input int prev_won);
    for (int i = 0; i < N_REQ; i++) begin
      if (!(bus.req[i] && prev_won != i)) bus.req[i] = ($urandom % 3) != 0;
      bus.lock[i]                   = ($urandom % 4) != 0;
      bus.we[i]                     = $urandom % 2;
      bus.addr[i*ADDR_W +: ADDR_W]  = ADDR_W'($urandom_range(0, 15));
      bus.wdata[i*DATA_W +: DATA_W] = $urandom;
    end
  endtask

  initial begin
    int won;
    logic [DATA_W-1:0] saved;
    int k;

    rst = 1'b1;
    clearPorts();
    for (int i = 0; i < 16; i++) begin
      dut_mem[i] = $urandom;
      ref_mem[i] = dut_mem[i];
    end
    dut_mem[5] = 32'hA5;
    ref_mem[5] = 32'hA5;
    modelReset();
    @(negedge clk);
    @(negedge clk);

    // Reset values with a CPU request pending.
    bus.req = 2'b01;
    #1;
    checkOutput("rst_gnt", bus.gnt, '0);
    checkOutput("rst_stall", bus.stall, 1'b1);
    checkOutput("rst_mem_we", bus.mem_we, 1'b0);
    checkOutput("rst_mem_addr", bus.mem_addr, '0);
    checkOutput("rst_rvalid", bus.rvalid, '0);
    checkOutput("rst_rdata", bus.rdata, '0);
    clearPorts();
    @(negedge clk);
    rst = 1'b0;

    // Single read of address 5.
    setPort(0, 1'b1, 1'b0, 1'b0, 32'd5, '0);
    runCycle(won);
    checkOutput("single_gnt", last_gnt, 2'b01);
    checkOutput("single_rvalid", bus.rvalid, 2'b01);
    checkOutput("single_rdata", bus.rdata, 32'hA5);
    clearPorts();
    runCycle(won);

    // Contention straight after reset alternates starting with port 0.
    doReset();
    setPort(0, 1'b1, 1'b0, 1'b0, 32'd1, '0);
    setPort(1, 1'b1, 1'b0, 1'b0, 32'd2, '0);
    for (int c = 0; c < 4; c++) begin
      runCycle(won);
      checkOutput("contend_gnt", last_gnt, (c % 2 == 0) ? 2'b01 : 2'b10);
    end
    clearPorts();
    runCycle(won);

    // Lock bound: port 1 locked, port 0 arrives at cycle 2 and wins on the 9th cycle.
    doReset();
    setPort(1, 1'b1, 1'b1, 1'b0, 32'd4, '0);
    for (int c = 0; c < 9; c++) begin
      if (c == 2) setPort(0, 1'b1, 1'b0, 1'b0, 32'd6, '0);
      runCycle(won);
      checkOutput("lock_bound_gnt", last_gnt, (c < 8) ? 2'b10 : 2'b01);
    end
    clearPorts();
    runCycle(won);

    // Write 0xDEAD via port 1, then read it back via port 0.
    setPort(1, 1'b1, 1'b0, 1'b1, 32'd3, 32'hDEAD);
    runCycle(won);
    clearPorts();
    setPort(0, 1'b1, 1'b0, 1'b0, 32'd3, '0);
    runCycle(won);
    checkOutput("wr_rd_rvalid", bus.rvalid, 2'b01);
    checkOutput("wr_rd_rdata", bus.rdata, 32'hDEAD);
    clearPorts();

    // Reset arriving in the grant cycle of a write must suppress it.
    setPort(1, 1'b1, 1'b0, 1'b1, 32'd7, 32'h1234);
    saved = dut_mem[7];
    #1;
    checkOutput("rstw_gnt_pre", bus.gnt, 2'b10);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rstw_gnt", bus.gnt, '0);
    checkOutput("rstw_mem_we", bus.mem_we, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rstw_mem7", dut_mem[7], saved);
    @(negedge clk);
    rst = 1'b0;
    setPort(0, 1'b1, 1'b0, 1'b0, 32'd2, '0);
    runCycle(won);
    checkOutput("rstw_first", last_gnt, 2'b01);
    clearPorts();
    runCycle(won);

    // Dropping lock mid-burst hands the port to the waiting requester next cycle.
    doReset();
    setPort(1, 1'b1, 1'b1, 1'b0, 32'd8, '0);
    for (int c = 0; c < 3; c++) runCycle(won);
    setPort(0, 1'b1, 1'b0, 1'b0, 32'd9, '0);
    runCycle(won);
    checkOutput("release_hold", last_gnt, 2'b10);
    bus.lock[1] = 1'b0;
    runCycle(won);
    checkOutput("release_last", last_gnt, 2'b10);
    runCycle(won);
    checkOutput("release_next", last_gnt, 2'b01);
    clearPorts();

    // Randomised traffic; waiting requesters hold req until served.
    doReset();
    for (int i = 0; i < N_REQ; i++) wait_cnt[i] = 0;
    won = -1;
    for (k = 0; k < 3000; k++) begin
      applyStimulus(won);
      runCycle(won);
      for (int i = 0; i < N_REQ; i++) begin
        if (won == i) begin
          checkOutput("wait_bound", (wait_cnt[i] + 1) <= WAIT_BOUND, 1'b1);
          wait_cnt[i] = 0;
        end else if (bus.req[i]) begin
          wait_cnt[i]++;
        end else begin
          wait_cnt[i] = 0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter that shares the single-port `data_memory` between `N_REQ` requesters: the CPU load/store port and debug/loader ports.
- Sits between the requesters and `data_memory`, and drives its `addr`/`we`/`wd`.
- Returns read data through a registered response.
- Supports short locked bursts, with a bounded lock length so no requester starves.
- Produces a stall indication for the CPU port.

## Interface
- `N_REQ`, default 2: number of requesters; index 0 is the CPU port.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `LOCK_MAX`, default 8: maximum consecutive grants to one locked owner while others wait.

- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in N_REQ: access request per requester, level-held until granted.
- `lock` in N_REQ: requester wants to keep ownership after this grant.
- `we` in N_REQ: 1 = write, 0 = read.
- `addr` in N_REQ*ADDR_W: flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- `wdata` in N_REQ*DATA_W: flattened write data.
- `gnt` out N_REQ: one-hot; access performed this cycle.
- `rvalid` out N_REQ: read data valid for requester i.
- `rdata` out DATA_W: registered read data shared by all requesters; qualified by `rvalid`.
- `stall` out 1: `req[0] & ~gnt[0]`.
- `mem_addr` out ADDR_W: to `data_memory.addr`.
- `mem_we` out 1: to `data_memory.we`.
- `mem_wd` out DATA_W: to `data_memory.wd`.
- `mem_rd` in DATA_W: from `data_memory.rd`; combinational read.

## Operation
- **FSM states**
  - `ARB`: no owner. Grant the first requesting index after `rr_ptr`, searching cyclically.
    - Granted with its `lock` high → go to `LOCKED`, set `owner`, set `lock_cnt` = 1.
  - `LOCKED`: grant `owner` if `req[owner]`.
    - `req[owner]` and `lock[owner]` both high → `lock_cnt`++.
    - Return to `ARB` when either `req[owner]` or `lock[owner]` is low.
    - Return to `ARB` when `lock_cnt == LOCK_MAX` and another requester is waiting; that cycle grants the round-robin pick, excluding `owner`.
    - With no other requester waiting, `lock_cnt` saturates at `LOCK_MAX` and ownership continues.
    - A cycle in `LOCKED` with `req[owner]` low grants nobody. The FSM returns to `ARB` at the following edge.
- **Round-robin pointer**
  - `rr_ptr` is set to the granted index on every grant.
  - Search order is `rr_ptr+1 … N_REQ-1, 0 … rr_ptr`, modulo `N_REQ`.
- **Memory port**
  - `mem_addr`, `mem_we`, `mem_wd` are muxed from the granted requester.
  - `mem_we` is gated by `gnt`.
  - With no grant, all three are 0.
- **Reads**
  - `mem_rd` is captured into `rdata` at the end of the grant cycle.
  - `rvalid[i]` pulses for exactly one cycle.
  - `rdata` holds its value until the next read.
- **Writes**: no response; the write commits at the edge ending the grant cycle.
- **Counter width**: `lock_cnt` is `$clog2(LOCK_MAX+1)` bits.
- **Bad `lock`**: `lock` without `req` is ignored.

## Timing
- **Grant latency**: `gnt` is combinational from `req` and state, so the grant comes in the same cycle as the request when the requester wins.
- **Read latency**: `rvalid` and `rdata` arrive 1 cycle after `gnt`.
- **Back-to-back**: one access per cycle, 100% port utilisation.
- **Bound on wait**: any requester is granted within `(N_REQ-1)*LOCK_MAX + N_REQ` cycles of raising `req`.
- **Reset values**
  - Outputs: `gnt`=0, `rvalid`=0, `rdata`=0, `stall` = `req[0]`, `mem_*`=0.
  - State: FSM=`ARB`, `rr_ptr`=`N_REQ-1` so index 0 wins first, `lock_cnt`=0, `owner`=0.
- **Reset mid-operation**
  - While `rst` is high, `gnt` is forced to 0, so no write commits.
  - A pending `rvalid` is dropped.
  - A lock in progress is abandoned.
- **Requester change while waiting**: changing `addr`, `we` or `wdata` while waiting (`req` high, `gnt` low) is legal. Only the values in the grant cycle are used.

## Structure
- **Package `dmem_arb_pkg`**
  - State enum `arb_state_t {ARB, LOCKED}`.
  - Pure function `rr_next(req, ptr, mask)` returning the one-hot pick.
- **Sub-module `rr_priority_picker`**: combinational, parameterised by `N_REQ`; inputs `req`, `ptr`, `exclude_mask`; outputs `onehot` and `idx`.
- **Top**: `dmem_arbiter` holds the FSM, `rr_ptr`, `owner`, `lock_cnt`, the response register and the memory-port mux.

## Test plan
- **Single read**: `req[0]`=1, `we`=0, addr 5, with `data_memory[5]`=0xA5 → `gnt[0]` in cycle 0; `rvalid[0]`=1 and `rdata`=0xA5 in cycle 1; `stall`=0.
- **Contention after reset**: `req`=11 every cycle, all reads → grants alternate `gnt`=01, 10, 01, 10; `stall`=1 exactly in the cycles where `gnt`=10.
- **Lock bound**: `req[1]` and `lock[1]` held, `req[0]` raised at cycle 2, `LOCK_MAX`=8 → `gnt[1]` for 8 consecutive cycles, then `gnt[0]` at the 9th; `rvalid` follows each read grant by one cycle.
- **Write then read**: port 1 writes 0xDEAD to addr 3; port 0 then reads addr 3 → `rdata`=0xDEAD, `rvalid[0]` 1 cycle after its grant.
- **Reset during write**: `rst` asserted in the grant cycle of a write of 0x1234 to addr 7 → `mem_we`=0, addr 7 unchanged; after release, index 0 wins first.
- **Lock release**: `lock[1]` dropped mid-burst while `req[0]` is pending → port 0 is granted in the next cycle.
